ticket_sched: RTL and testbench

//  Shares one in-order ticket space among NREQ requesters: round-robin grants one ticket per cycle,

---
 rtl/ticket_sched_pkg.sv | 14 +
 rtl/ticket_sched_rr_arbiter.sv | 33 +++
 rtl/ticket_sched.sv | 94 +++++++++
 tb/tb_ticket_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ticket_sched_pkg.sv
// rtl/ticket_sched_pkg.sv - shared ticket-space constants, types and helpers
package ticket_sched_pkg;

  localparam int TICKET_W = 4;
  localparam int DEPTH    = 1 << TICKET_W;

  typedef logic [TICKET_W-1:0] ticket_t;

  // Width needed to index n requesters; never below 1 bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ticket_sched_rr_arbiter.sv
// rtl/ticket_sched_rr_arbiter.sv - combinational round-robin arbiter starting after rrLast
module rr_arbiter
  import ticket_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rrLast,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner
);

  logic found;
  int   idx;

  // Scan from the requester after the previous winner, wrapping; first hit wins.
  always_comb begin
    grant  = '0;
    winner = rrLast;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(rrLast) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ticket_sched.sv
// rtl/ticket_sched.sv - in-order ticket allocator with out-of-order completion scoreboard
module ticket_sched #(
  parameter int NREQ     = 4,
  parameter int TICKET_W = ticket_sched_pkg::TICKET_W
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     grant,
  output logic [TICKET_W-1:0] grant_ticket,
  input  logic                complete__ENA,
  input  logic [TICKET_W-1:0] complete_ticket,
  output logic                complete__RDY,
  output logic                retire__ENA,
  output logic [TICKET_W-1:0] retire_ticket,
  output logic [TICKET_W:0]   in_flight,
  output logic                full,
  output logic                empty,
  output logic                err
);

  localparam int DEPTH = 1 << TICKET_W;
  localparam int CNT_W = TICKET_W + 1;
  localparam int IW    = ticket_sched_pkg::idxWidth(NREQ);

  logic [TICKET_W-1:0] head;
  logic [TICKET_W-1:0] tail;
  logic [IW-1:0]       rrLast;
  logic [DEPTH-1:0]    valid;
  logic [DEPTH-1:0]    done;

  logic [NREQ-1:0] arbGrant;
  logic [IW-1:0]   arbWinner;
  logic            alloc;
  logic            retireNow;
  logic            completeOk;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) uArb (
    .req    (req),
    .rrLast (rrLast),
    .grant  (arbGrant),
    .winner (arbWinner)
  );

  // Grants come from registered state only; nothing is granted while in reset or full.
  always_comb begin
    alloc        = nRST && !full && (|req);
    grant        = alloc ? arbGrant : '0;
    grant_ticket = tail;
    retireNow    = valid[head] && done[head];
    completeOk   = complete__ENA && valid[complete_ticket] && !done[complete_ticket];
  end

  assign complete__RDY = 1'b1;
  assign full          = (in_flight == CNT_W'(DEPTH));
  assign empty         = (in_flight == '0);

  // Scoreboard, pointers, occupancy count and retire/error outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head          <= '0;
      tail          <= '0;
      rrLast        <= IW'(NREQ - 1);
      valid         <= '0;
      done          <= '0;
      in_flight     <= '0;
      retire__ENA   <= 1'b0;
      retire_ticket <= '0;
      err           <= 1'b0;
    end else begin
      // Retire, allocate and complete never touch the same slot in one cycle:
      // a retiring slot is done, a completing slot is not, and tail only meets
      // an occupied head when full (no alloc).
      if (retireNow) begin
        valid[head]   <= 1'b0;
        head          <= head + 1'b1;
        retire_ticket <= head;
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= tail + 1'b1;
        rrLast      <= arbWinner;
      end
      if (completeOk) begin
        done[complete_ticket] <= 1'b1;
      end
      retire__ENA <= retireNow;
      in_flight   <= in_flight + CNT_W'(alloc) - CNT_W'(retireNow);
      err         <= err | (complete__ENA && !completeOk);
    end
  end

endmodule

// File: tb/tb_ticket_sched.sv
// tb/tb_ticket_sched.sv - directed self-checking bench for ticket_sched
module tb_ticket_sched;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] grantTicket;
  logic       completeEna;
  logic [3:0] completeTicket;
  logic       completeRdy;
  logic       retireEna;
  logic [3:0] retireTicket;
  logic [4:0] inFlight;
  logic       full;
  logic       empty;
  logic       err;

  int checks = 0;
  int errors = 0;

  ticket_sched #(.NREQ(4), .TICKET_W(4)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .req             (req),
    .grant           (grant),
    .grant_ticket    (grantTicket),
    .complete__ENA   (completeEna),
    .complete_ticket (completeTicket),
    .complete__RDY   (completeRdy),
    .retire__ENA     (retireEna),
    .retire_ticket   (retireTicket),
    .in_flight       (inFlight),
    .full            (full),
    .empty           (empty),
    .err             (err)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    nRST        = 1'b0;
    req         = 4'b0000;
    completeEna = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic allocN(input int n);
    req = 4'b0001;
    repeat (n) tick();
    req = 4'b0000;
    #1;
  endtask

  task automatic completeOne(input logic [3:0] t);
    completeEna    = 1'b1;
    completeTicket = t;
    tick();
    completeEna = 1'b0;
    #1;
  endtask

  initial begin
    nRST           = 1'b0;
    req            = 4'b1111;
    completeEna    = 1'b0;
    completeTicket = 4'd0;

    // Reset held with all requests asserted
    tick();
    tick();
    checkVal("rst_grant", grant, 4'b0000);
    checkVal("rst_empty", empty, 1'b1);
    checkVal("rst_full", full, 1'b0);
    checkVal("rst_inflight", inFlight, 5'd0);
    checkVal("rst_err", err, 1'b0);
    checkVal("rst_retire", retireEna, 1'b0);
    checkVal("cmp_rdy", completeRdy, 1'b1);

    // Fairness: all requesting rotates 0,1,2,3
    nRST = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("fair_grant%0d", i), grant, 4'b0001 << i);
      checkVal($sformatf("fair_ticket%0d", i), grantTicket, i);
      tick();
    end
    // Sparse requests skip idle requesters
    req = 4'b0101;
    #1;
    checkVal("sparse_g0", grant, 4'b0001);
    tick();
    checkVal("sparse_g1", grant, 4'b0100);
    checkVal("sparse_t1", grantTicket, 4'd5);
    tick();
    checkVal("sparse_g2", grant, 4'b0001);
    tick();
    req = 4'b0000;
    #1;
    checkVal("fair_inflight", inFlight, 5'd7);

    // Out-of-order completion, in-order retire
    doReset();
    allocN(3);
    checkVal("ooo_inflight", inFlight, 5'd3);
    completeOne(4'd2);
    completeOne(4'd1);
    tick();
    checkVal("ooo_noretire", retireEna, 1'b0);
    completeOne(4'd0);
    checkVal("ooo_lat1", retireEna, 1'b0);
    tick();
    checkVal("ooo_r0_ena", retireEna, 1'b1);
    checkVal("ooo_r0_t", retireTicket, 4'd0);
    checkVal("ooo_r0_cnt", inFlight, 5'd2);
    tick();
    checkVal("ooo_r1_ena", retireEna, 1'b1);
    checkVal("ooo_r1_t", retireTicket, 4'd1);
    checkVal("ooo_r1_cnt", inFlight, 5'd1);
    tick();
    checkVal("ooo_r2_ena", retireEna, 1'b1);
    checkVal("ooo_r2_t", retireTicket, 4'd2);
    checkVal("ooo_r2_cnt", inFlight, 5'd0);
    checkVal("ooo_empty", empty, 1'b1);
    tick();
    checkVal("ooo_idle", retireEna, 1'b0);
    checkVal("ooo_err", err, 1'b0);

    // Full: requests wait, resume with wrapped ticket 0 after a retire
    doReset();
    req = 4'b0001;
    repeat (16) tick();
    checkVal("full_flag", full, 1'b1);
    checkVal("full_cnt", inFlight, 5'd16);
    checkVal("full_grant", grant, 4'b0000);
    checkVal("full_empty", empty, 1'b0);
    completeOne(4'd0);
    checkVal("full_retire_cycle_grant", grant, 4'b0000);
    tick();
    checkVal("full_ret_ena", retireEna, 1'b1);
    checkVal("full_ret_cnt", inFlight, 5'd15);
    checkVal("full_resume_grant", grant, 4'b0001);
    checkVal("full_wrap_ticket", grantTicket, 4'd0);
    tick();
    checkVal("full_refill", full, 1'b1);
    req = 4'b0000;

    // Simultaneous allocate and retire keeps the count
    doReset();
    allocN(5);
    completeOne(4'd0);
    req = 4'b0001;
    #1;
    checkVal("sim_ticket", grantTicket, 4'd5);
    tick();
    checkVal("sim_cnt", inFlight, 5'd5);
    checkVal("sim_ret_ena", retireEna, 1'b1);
    checkVal("sim_ret_t", retireTicket, 4'd0);
    req = 4'b0000;
    #1;
    checkVal("sim_next_ticket", grantTicket, 4'd6);

    // Completion of a non-outstanding ticket
    completeOne(4'd7);
    checkVal("bad_err", err, 1'b1);
    checkVal("bad_cnt", inFlight, 5'd5);
    checkVal("bad_noretire", retireEna, 1'b0);
    tick();
    checkVal("bad_sticky", err, 1'b1);
    completeOne(4'd1);
    tick();
    checkVal("bad_ret_ena", retireEna, 1'b1);
    checkVal("bad_ret_t", retireTicket, 4'd1);

    // Duplicate completion
    doReset();
    checkVal("dup_err_clear", err, 1'b0);
    allocN(2);
    completeOne(4'd1);
    checkVal("dup_first_ok", err, 1'b0);
    completeOne(4'd1);
    checkVal("dup_err", err, 1'b1);
    checkVal("dup_cnt", inFlight, 5'd2);

    // Completing the ticket being allocated in the same cycle
    doReset();
    req = 4'b0001;
    completeOne(4'd0);
    req = 4'b0000;
    #1;
    checkVal("same_err", err, 1'b1);
    checkVal("same_cnt", inFlight, 5'd1);

    // Reset mid-run discards outstanding tickets
    doReset();
    allocN(6);
    checkVal("mid_cnt6", inFlight, 5'd6);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    checkVal("mid_cnt0", inFlight, 5'd0);
    checkVal("mid_empty", empty, 1'b1);
    req = 4'b0001;
    #1;
    checkVal("mid_grant", grant, 4'b0001);
    checkVal("mid_ticket", grantTicket, 4'd0);
    tick();
    checkVal("mid_cnt1", inFlight, 5'd1);
    req = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
